// File: rtl/vend_pkg.sv
// Shared vending definitions: transaction state encoding and default sizing,
// reused by the arbiter and the per-panel coin front ends.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2,
        ST_DONE     = 2'd3
    } vend_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_CREDIT_W = 4;
    localparam int DEF_PRICE    = 6;
    localparam int DEF_CHG_GAP  = 4;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after rr_ptr_i,
// wrapping modulo N_REQ, so the last-served panel has lowest priority.
module vend_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int cand;

    // Scan from the farthest offset down so the nearest eligible panel wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(rr_ptr_i) + off) % N_REQ;
            if (elig_i[cand]) begin
                idx_o   = IDX_W'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one pencil dispenser and change hopper among panels;
// sequences dispense, ack/timeout, coin-by-coin change, and completion.
module vend_arbiter
    import vend_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int CREDIT_W = DEF_CREDIT_W,
    parameter int PRICE    = DEF_PRICE,
    parameter int CHG_GAP  = DEF_CHG_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*CREDIT_W-1:0] req_credit_i,
    input  logic                      disp_ack_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      dispense_out_o,
    output logic                      change_out_o,
    output logic                      done_o,
    output logic                      fault_o,
    output logic                      busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(CHG_GAP);

    vend_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_W-1:0] cred_q, cred_d;
    logic [CREDIT_W-1:0] chg_q, chg_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                fault_q, fault_d;

    logic [N_REQ-1:0]    elig;
    logic [CREDIT_W-1:0] credit_arr [N_REQ];
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_panel
        assign credit_arr[gi] = req_credit_i[gi*CREDIT_W +: CREDIT_W];
        assign elig[gi]       = req_i[gi] && (credit_arr[gi] >= CREDIT_W'(PRICE));
        assign grant_o[gi]    = (state_q != ST_IDLE) && (idx_q == IDX_W'(gi));
    end

    vend_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig_i   (elig),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= IDX_W'(N_REQ - 1);
            cred_q   <= '0;
            chg_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            cred_q   <= cred_d;
            chg_q    <= chg_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        cred_d   = cred_q;
        chg_d    = chg_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        fault_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    cred_d  = credit_arr[pick_idx];
                    tmo_d   = '0;
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                tmo_d = tmo_q + 1'b1;
                gap_d = '0;
                // An ack on the expiry cycle still counts as a successful drop.
                if (disp_ack_i) begin
                    chg_d   = cred_q - CREDIT_W'(PRICE);
                    state_d = (cred_q != CREDIT_W'(PRICE)) ? ST_CHANGE : ST_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    chg_d   = cred_q;
                    fault_d = 1'b1;
                    state_d = (cred_q != '0) ? ST_CHANGE : ST_DONE;
                end
            end
            ST_CHANGE: begin
                if (gap_q == GAP_W'(CHG_GAP - 1)) begin
                    chg_d = chg_q - 1'b1;
                    gap_d = '0;
                    if (chg_q == CREDIT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                rr_ptr_d = idx_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dispense_out_o = (state_q == ST_DISPENSE);
    assign change_out_o   = (state_q == ST_CHANGE) && (gap_q == '0);
    assign done_o         = (state_q == ST_DONE);
    assign fault_o        = fault_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench: each transaction's full output timeline is predicted from
// the arbitration rule, ack delay and credit, then compared cycle by cycle.
module tb_vend_arbiter;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int PRICE = 6;
    localparam int GAP   = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic [N*CW-1:0] req_credit_i = '0;
    logic          disp_ack_i = 1'b0;
    logic [N-1:0]  grant_o;
    logic          dispense_out_o, change_out_o, done_o, fault_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int rr       = N - 1;

    vend_arbiter #(
        .N_REQ(N), .CREDIT_W(CW), .PRICE(PRICE), .CHG_GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req_i),
        .req_credit_i   (req_credit_i),
        .disp_ack_i     (disp_ack_i),
        .grant_o        (grant_o),
        .dispense_out_o (dispense_out_o),
        .change_out_o   (change_out_o),
        .done_o         (done_o),
        .fault_o        (fault_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed order: {grant[3:0], dispense, change, done, fault, busy}
    task automatic expect_out(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {grant_o, dispense_out_o, change_out_o, done_o, fault_o, busy_o};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] rq, input logic [N*CW-1:0] cr, input int last);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (last + off) % N;
            if (rq[i] && (cr[i*CW +: CW] >= PRICE)) return i;
        end
        return -1;
    endfunction

    // ack_k: 1-based DISPENSE cycle whose closing edge sees disp_ack; >TMO means never.
    // abort_at: timeline index after which reset is asserted (-1 = none).
    task automatic txn(input logic [N-1:0] rq, input logic [N*CW-1:0] cr,
                       input int ack_k, input int abort_at, input int idle_len);
        int          w, d, n, cred;
        bit          flt;
        logic [3:0]  g;
        logic [8:0]  tl[$];
        req_i        = rq;
        req_credit_i = cr;
        disp_ack_i   = 1'($urandom_range(0, 1));
        w = model_pick(rq, cr, rr);
        if (w < 0) begin
            for (int c = 0; c < idle_len; c++) begin
                step();
                expect_out("idle_inelig", 9'd0);
            end
            $display("txn req=%b cred=%h -> no grant", rq, cr);
            return;
        end
        cred = int'(cr[w*CW +: CW]);
        flt  = (ack_k > TMO);
        d    = flt ? TMO : ack_k;
        n    = flt ? cred : cred - PRICE;
        g    = 4'b0001 << w;
        for (int c = 0; c < d; c++) tl.push_back({g, 5'b10001});
        for (int c = 0; c < n * GAP; c++)
            tl.push_back({g, 1'b0, (c % GAP) == 0, 1'b0, flt && (c == 0), 1'b1});
        tl.push_back({g, 1'b0, 1'b0, 1'b1, flt && (n == 0), 1'b1});
        for (int j = 0; j < tl.size(); j++) begin
            step();
            expect_out($sformatf("txn_p%0d_cyc%0d", w, j), tl[j]);
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                expect_out("rst_abort_now", 9'd0);
                repeat (2) begin
                    step();
                    expect_out("rst_abort_hold", 9'd0);
                end
                rst_n      = 1'b1;
                req_i      = '0;
                disp_ack_i = 1'b0;
                rr         = N - 1;
                step();
                expect_out("rst_abort_idle", 9'd0);
                $display("txn panel=%0d cred=%0d aborted by reset at cycle %0d", w, cred, j);
                return;
            end
            req_i        = N'($urandom);
            req_credit_i = (N*CW)'($urandom);
            disp_ack_i   = (j < d) ? (j + 1 == ack_k) : 1'($urandom_range(0, 1));
        end
        rr = w;
        step();
        expect_out("post_idle", 9'd0);
        $display("txn panel=%0d cred=%0d ack_k=%0d fault=%0d change=%0d", w, cred, ack_k, flt, n);
    endtask

    initial begin
        #1;
        expect_out("reset_async", 9'd0);
        repeat (2) step();
        expect_out("reset_hold", 9'd0);
        rst_n = 1'b1;

        // Two panels both requesting: 0 then 1, twice.
        txn(4'b0011, 16'h0066, 1, -1, 0);
        txn(4'b0011, 16'h0066, 1, -1, 0);
        txn(4'b0011, 16'h0066, 3, -1, 0);
        txn(4'b0011, 16'h0066, 2, -1, 0);
        // Exact price, ack after 2 cycles: no change.
        txn(4'b0001, 16'h0006, 2, -1, 0);
        // 9 credits, immediate ack: 3 change pulses.
        txn(4'b0010, 16'h0090, 1, -1, 0);
        // Insufficient credit: ignored for 50 cycles.
        txn(4'b0100, 16'h0500, 1, -1, 50);
        // Never acked: timeout, fault, full refund of 8.
        txn(4'b1000, 16'h8000, 99, -1, 0);
        // Ack on the very cycle the timeout expires; max credit.
        txn(4'b0100, 16'h0F00, TMO, -1, 0);
        // Reset after the 2nd of 3 change pulses (timeline index 5).
        txn(4'b0010, 16'h0090, 1, 5, 0);
        // After reset, the lowest eligible index wins.
        txn(4'b1110, 16'h7770, 1, -1, 0);
        txn(4'b1111, 16'h6666, 1, -1, 0);

        for (int t = 0; t < 40; t++) begin
            txn(N'($urandom), (N*CW)'($urandom), int'($urandom_range(1, TMO + 3)), -1, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
